// File: rtl/instruction_encode_loader_if.sv
// instruction_encode_loader_if: field-bundle input and single-beat memory write port
interface instruction_encode_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        mem_we;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instruction_encode_loader.sv
// instruction_encode_loader: encodes RV32I fields into words and writes them sequentially to memory
module instruction_encode_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          DEPTH_WORDS = 1024,
    localparam int         CW          = $clog2(DEPTH_WORDS + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    instruction_encode_loader_if.slave bus,
    input  logic                       restart,
    output logic [CW-1:0]              count,
    output logic                       full,
    output logic                       err,
    output logic [1:0]                 err_code
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;
    logic          pend_q, pend_d;

    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] enc;
    logic        legal, in_range;
    logic        i_ok, sh_ok, b_ok, j_ok, is_shift;
    logic        hs;

    assign op  = bus.in_opcode;
    assign rd  = bus.in_rd;
    assign rs1 = bus.in_rs1;
    assign rs2 = bus.in_rs2;
    assign f3  = bus.in_funct3;
    assign f7  = bus.in_funct7;
    assign imm = bus.in_imm;

    // Immediate must be representable after sign-extension from the field width
    assign i_ok     = &imm[31:11] | ~|imm[31:11];
    assign sh_ok    = ~|imm[31:5];
    assign b_ok     = !imm[0] && (&imm[31:12] | ~|imm[31:12]);
    assign j_ok     = !imm[0] && (&imm[31:20] | ~|imm[31:20]);
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    always_comb begin
        enc      = '0;
        legal    = 1'b1;
        in_range = 1'b1;
        case (op)
            OP_R: enc = {f7, rs2, rs1, f3, rd, op};
            OP_IMM: begin
                enc      = is_shift ? {f7, imm[4:0], rs1, f3, rd, op} : {imm[11:0], rs1, f3, rd, op};
                in_range = is_shift ? sh_ok : i_ok;
            end
            OP_LOAD, OP_JALR: begin
                enc      = {imm[11:0], rs1, f3, rd, op};
                in_range = i_ok;
            end
            OP_STORE: begin
                enc      = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
                in_range = i_ok;
            end
            OP_BRANCH: begin
                enc      = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
                in_range = b_ok;
            end
            OP_LUI, OP_AUIPC: enc = {imm[31:12], rd, op};
            OP_JAL: begin
                enc      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                in_range = j_ok;
            end
            default: legal = 1'b0;
        endcase
    end

    assign full         = count_q == CW'(DEPTH_WORDS);
    assign bus.in_ready = (state_q == IDLE) && !full && !restart;
    assign hs           = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        err_d   = err_q;
        code_d  = code_q;
        pend_d  = pend_q;
        if (state_q == IDLE) begin
            if (restart) begin
                addr_d  = BASE_ADDR;
                count_d = '0;
                err_d   = 1'b0;
                code_d  = 2'b00;
            end else if (hs && legal && in_range) begin
                wdata_d = enc;
                state_d = WRITE;
            end else if (hs && !err_q) begin
                err_d  = 1'b1;
                code_d = legal ? 2'b10 : 2'b01;
            end
        end else begin
            pend_d = pend_q | restart;
            // A restart seen during the write lets it finish, then discards the session
            if (bus.mem_ready) begin
                state_d = IDLE;
                pend_d  = 1'b0;
                if (pend_q || restart) begin
                    addr_d  = BASE_ADDR;
                    count_d = '0;
                    err_d   = 1'b0;
                    code_d  = 2'b00;
                end else begin
                    addr_d  = addr_q + 32'd4;
                    count_d = count_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            err_q   <= err_d;
            code_q  <= code_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.mem_we    = state_q == WRITE;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign count         = count_q;
    assign err           = err_q;
    assign err_code      = code_q;
endmodule

// File: tb/tb_instruction_encode_loader.sv
// tb_instruction_encode_loader: vector table plus corner sequences, writes checked through a scoreboard
module tb_instruction_encode_loader;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       restart = 1'b0;
    logic [2:0] count;
    logic       full, err;
    logic [1:0] err_code;

    always #5 clk = ~clk;

    instruction_encode_loader_if bus();

    instruction_encode_loader #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .reset(reset), .bus(bus), .restart(restart),
        .count(count), .full(full), .err(err), .err_code(err_code)
    );

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] word;
        logic [1:0]  code;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] sb[$];
    logic [63:0] sb_e;
    logic [31:0] exp_addr = BASE;
    int          exp_count = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.mem_we && bus.mem_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %h data %h want no write", bus.mem_addr, bus.mem_wdata);
            end else begin
                sb_e = sb.pop_front();
                check("wr_addr", bus.mem_addr, sb_e[63:32]);
                check("wr_data", bus.mem_wdata, sb_e[31:0]);
            end
        end
    end

    task automatic add(input string name, input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm, input logic [31:0] word, input logic [1:0] code);
        vec_t v;
        v.name = name; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.f3 = f3; v.f7 = f7; v.imm = imm; v.word = word; v.code = code;
        vecs.push_back(v);
    endtask

    task automatic set_fields(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm);
        bus.in_opcode = op; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
        bus.in_funct3 = f3; bus.in_funct7 = f7; bus.in_imm = imm;
    endtask

    task automatic send(input string name, input logic exp_wr, input logic [31:0] word);
        int t = 0;
        bus.in_valid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.in_ready && t < 50);
        if (!bus.in_ready) begin
            check({name, "_accept"}, 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        if (exp_wr) sb.push_back({exp_addr, word});
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        check({name, "_we"}, 32'(bus.mem_we), 32'(exp_wr));
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({name, "_drain"}, sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        drain(name);
        exp_addr += 32'd4;
        exp_count++;
        check({name, "_count"}, 32'(count), 32'(exp_count));
        check({name, "_addr"}, bus.mem_addr, exp_addr);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
        exp_addr  = BASE;
        exp_count = 0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.mem_ready = 1'b1;
        set_fields(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        add("addi",      7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'b0000000, 32'd5,        32'h0050_0093, 2'b00);
        add("srai",      7'b0010011, 5'd3, 5'd3, 5'd0, 3'b101, 7'b0100000, 32'd4,        32'h4041_D193, 2'b00);
        add("sw",        7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'b0000000, 32'd8,        32'h0020_A423, 2'b00);
        add("beq",       7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'b0000000, 32'hFFFF_FFFC, 32'hFE20_8EE3, 2'b00);
        add("lui",       7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'b0000000, 32'h1234_5ABC, 32'h1234_52B7, 2'b00);
        add("add",       7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'b0000000, 32'd0,        32'h0020_81B3, 2'b00);
        add("lw_neg",    7'b0000011, 5'd4, 5'd2, 5'd0, 3'b010, 7'b0000000, 32'hFFFF_FFFC, 32'hFFC1_2203, 2'b00);
        add("addi_min",  7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'b0000000, 32'hFFFF_F800, 32'h8000_0093, 2'b00);
        add("slli_31",   7'b0010011, 5'd1, 5'd1, 5'd0, 3'b001, 7'b0000000, 32'd31,       32'h01F0_9093, 2'b00);
        add("addi_big",  7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'b0000000, 32'h0000_0800, 32'd0,        2'b10);
        add("slli_32",   7'b0010011, 5'd1, 5'd1, 5'd0, 3'b001, 7'b0000000, 32'd32,       32'd0,        2'b10);
        add("beq_odd",   7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'b0000000, 32'd3,        32'd0,        2'b10);
        add("jal_big",   7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'b0000000, 32'h0010_0000, 32'd0,        2'b10);
        add("ecall_op",  7'b1110011, 5'd0, 5'd0, 5'd0, 3'b000, 7'b0000000, 32'd0,        32'd0,        2'b01);
        add("zero_op",   7'b0000000, 5'd0, 5'd0, 5'd0, 3'b000, 7'b0000000, 32'd0,        32'd0,        2'b01);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_addr", bus.mem_addr, BASE);
        check("rst_wdata", bus.mem_wdata, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_code", 32'(err_code), 32'd0);

        foreach (vecs[i]) begin
            if (exp_count == DEPTH) begin
                check("tbl_full", 32'(full), 32'd1);
                check("tbl_full_ready", 32'(bus.in_ready), 32'd0);
            end
            if (vecs[i].code != 2'b00 || exp_count == DEPTH) do_restart();
            set_fields(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].f3, vecs[i].f7, vecs[i].imm);
            send(vecs[i].name, vecs[i].code == 2'b00, vecs[i].word);
            if (vecs[i].code == 2'b00) wait_done(vecs[i].name);
            else begin
                check({vecs[i].name, "_err"}, 32'(err), 32'd1);
                check({vecs[i].name, "_code"}, 32'(err_code), 32'(vecs[i].code));
                check({vecs[i].name, "_count"}, 32'(count), 32'(exp_count));
            end
        end

        // JAL held under backpressure
        do_restart();
        bus.mem_ready = 1'b0;
        set_fields(7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'b0000000, 32'h0000_0800);
        send("jal", 1'b1, 32'h0010_00EF);
        repeat (3) begin
            @(negedge clk);
            check("jal_hold_we", 32'(bus.mem_we), 32'd1);
            check("jal_hold_addr", bus.mem_addr, BASE);
            check("jal_hold_data", bus.mem_wdata, 32'h0010_00EF);
            check("jal_hold_ready", 32'(bus.in_ready), 32'd0);
            check("jal_hold_count", 32'(count), 32'd0);
        end
        @(posedge clk);
        #1 bus.mem_ready = 1'b1;
        wait_done("jal");

        // sticky error: first code wins until restart
        do_restart();
        set_fields(7'b1110011, 5'd0, 5'd0, 5'd0, 3'b000, 7'b0000000, 32'd0);
        send("stk_ill", 1'b0, 32'd0);
        check("stk_ill_code", 32'(err_code), 32'd1);
        set_fields(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'b0000000, 32'h0000_0800);
        send("stk_rng", 1'b0, 32'd0);
        check("stk_rng_code", 32'(err_code), 32'd1);
        check("stk_count", 32'(count), 32'd0);
        do_restart();
        check("stk_clr_err", 32'(err), 32'd0);
        send("stk_rng2", 1'b0, 32'd0);
        check("stk_rng2_code", 32'(err_code), 32'd2);

        // fill to DEPTH, then further bundles are refused
        do_restart();
        set_fields(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'b0000000, 32'd5);
        repeat (DEPTH) begin
            send("fill", 1'b1, 32'h0050_0093);
            wait_done("fill");
        end
        check("full_flag", 32'(full), 32'd1);
        check("full_ready", 32'(bus.in_ready), 32'd0);
        check("full_addr", bus.mem_addr, 32'h0000_1010);
        bus.in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.in_valid = 1'b0;
        check("full_ign_count", 32'(count), 32'd4);
        check("full_ign_we", 32'(bus.mem_we), 32'd0);
        do_restart();
        check("full_rst_count", 32'(count), 32'd0);
        check("full_rst_addr", bus.mem_addr, BASE);
        check("full_rst_flag", 32'(full), 32'd0);

        // restart coincident with a handshake drops the bundle
        bus.in_valid = 1'b1;
        restart = 1'b1;
        @(negedge clk);
        check("coin_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        restart = 1'b0;
        check("coin_we", 32'(bus.mem_we), 32'd0);
        check("coin_count", 32'(count), 32'd0);

        // restart during WRITE: write finishes at 0x1004, then session clears
        send("rw_first", 1'b1, 32'h0050_0093);
        wait_done("rw_first");
        bus.mem_ready = 1'b0;
        send("rw_second", 1'b1, 32'h0050_0093);
        restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
        check("rw_still_we", 32'(bus.mem_we), 32'd1);
        check("rw_still_addr", bus.mem_addr, 32'h0000_1004);
        @(posedge clk);
        #1 bus.mem_ready = 1'b1;
        drain("rw");
        exp_addr = BASE;
        exp_count = 0;
        check("rw_count", 32'(count), 32'd0);
        check("rw_addr", bus.mem_addr, BASE);
        check("rw_we", 32'(bus.mem_we), 32'd0);

        // reset mid-WRITE drops the write
        bus.mem_ready = 1'b0;
        send("rst_wr", 1'b1, 32'h0050_0093);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        sb.delete();
        bus.mem_ready = 1'b1;
        check("rstw_we", 32'(bus.mem_we), 32'd0);
        check("rstw_addr", bus.mem_addr, BASE);
        check("rstw_wdata", bus.mem_wdata, 32'd0);
        check("rstw_count", 32'(count), 32'd0);
        check("rstw_ready", 32'(bus.in_ready), 32'd1);
        check("rstw_err", 32'({err, err_code}), 32'd0);
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
